// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one N x M systolic matmul tile: clear, skewed feed, row-by-row drain, done pulse.
// Optional busy-cycle counter on perf_cycles is enabled by defining SEQ_PERF_CNT_EN.

module systolic_seq_lane #(
  parameter int TW  = 4,
  parameter int IDX = 0
) (
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] k,
  output logic          en
);
  // Lane IDX sees its k operand beats delayed by IDX cycles.
  assign en = (t >= TW'(IDX)) && (t < TW'(IDX) + k);
endmodule

module systolic_seq_ctrl #(
  parameter int N   = 2,
  parameter int M   = 2,
  parameter int K_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [K_W-1:0]       k_len,
  output logic                 busy,
  output logic                 acc_clr,
  output logic [N-1:0]         a_en,
  output logic [M-1:0]         b_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_row,
  output logic                 done,
  output logic [31:0]          perf_cycles
);
  // Wide enough for k_len max plus the full skew without wrapping.
  localparam int TW = $clog2((2**K_W) + N + M);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k_q, k_nxt;
  logic [TW-1:0]    t, t_nxt, k_ext, t_last;
  logic [N-1:0]     a_lane, a_nxt;
  logic [M-1:0]     b_lane, b_nxt;
  logic             busy_nxt, clr_nxt, ov_nxt, done_nxt;
  logic [RW-1:0]    row_nxt;

  assign k_ext  = {{(TW-K_W){1'b0}}, k_q};
  assign t_last = k_ext + TW'(N + M - 3);

  for (genvar i = 0; i < N; i++) begin : g_a
    systolic_seq_lane #(.TW(TW), .IDX(i)) u_lane (.t(t), .k(k_ext), .en(a_lane[i]));
  end
  for (genvar j = 0; j < M; j++) begin : g_b
    systolic_seq_lane #(.TW(TW), .IDX(j)) u_lane (.t(t), .k(k_ext), .en(b_lane[j]));
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_q;
    t_nxt     = t;
    busy_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    a_nxt     = '0;
    b_nxt     = '0;
    ov_nxt    = 1'b0;
    row_nxt   = out_row;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        row_nxt = '0;
        if (start) begin
          k_nxt     = k_len;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy_nxt  = 1'b1;
        clr_nxt   = 1'b1;
        t_nxt     = '0;
        row_nxt   = '0;
        state_nxt = (k_q != '0) ? COMPUTE : DRAIN;
      end
      COMPUTE: begin
        busy_nxt = 1'b1;
        a_nxt    = a_lane;
        b_nxt    = b_lane;
        t_nxt    = t + 1'b1;
        if (t == t_last) begin
          t_nxt     = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy_nxt = 1'b1;
        ov_nxt   = 1'b1;
        if (out_valid && out_ready) begin
          if (out_row == RW'(N - 1)) begin
            busy_nxt  = 1'b0;
            ov_nxt    = 1'b0;
            done_nxt  = 1'b1;
            row_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            row_nxt = out_row + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      t         <= '0;
      busy      <= 1'b0;
      acc_clr   <= 1'b0;
      a_en      <= '0;
      b_en      <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      k_q       <= k_nxt;
      t         <= t_nxt;
      busy      <= busy_nxt;
      acc_clr   <= clr_nxt;
      a_en      <= a_nxt;
      b_en      <= b_nxt;
      out_valid <= ov_nxt;
      out_row   <= row_nxt;
      done      <= done_nxt;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           perf_cycles <= '0;
    else if (state == IDLE && start)   perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
  end
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl (N=M=2, K_W=4): stimulus pushes expected events, monitor pops.
module tb_systolic_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [3:0]  k_len;
  logic        busy, acc_clr, out_valid, done;
  logic [1:0]  a_en, b_en;
  logic [0:0]  out_row;
  logic [31:0] perf_cycles;

  systolic_seq_ctrl #(.N(2), .M(2), .K_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .acc_clr(acc_clr),
    .a_en(a_en), .b_en(b_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       clr;
    logic [1:0] a;
    logic [1:0] b;
    logic       ov;
    logic       row;
    logic       dn;
    logic       bz;
    string      tag;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Any visible activity must match the next expected event, including its cycle.
  always @(negedge clk) begin
    if (acc_clr || (a_en != 2'b00) || (b_en != 2'b00) || out_valid || done) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output cyc=%0d clr=%b a=%b b=%b ov=%b row=%b done=%b required none",
                 cyc, acc_clr, a_en, b_en, out_valid, out_row, done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.clr == acc_clr && e.a == a_en && e.b == b_en && e.ov == out_valid &&
            e.row == out_row[0] && e.dn == done && e.bz == busy)
          n_pass++;
        else
          $display("FAIL %s got cyc=%0d clr=%b a=%b b=%b ov=%b row=%b done=%b busy=%b required cyc=%0d clr=%b a=%b b=%b ov=%b row=%b done=%b busy=%b",
                   e.tag, cyc, acc_clr, a_en, b_en, out_valid, out_row, done, busy,
                   e.cyc, e.clr, e.a, e.b, e.ov, e.row, e.dn, e.bz);
      end
    end
  end

  function automatic void push(int c, logic clr, logic [1:0] a, logic [1:0] b, logic ov,
                               logic row, logic dn, logic bz, string tag);
    ev_t e;
    e.cyc = c; e.clr = clr; e.a = a; e.b = b; e.ov = ov; e.row = row; e.dn = dn; e.bz = bz;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s got %0h required %0h", name, got, req);
  endtask

  // Generic tile expectation; returns the done cycle.
  function automatic int push_tile(int acc, int k, int s, string tag);
    int d;
    push(acc + 1, 1, 2'b00, 2'b00, 0, 0, 0, 1, {tag, "_clr"});
    if (k > 0) begin
      for (int t = 0; t < k + 2; t++) begin
        logic [1:0] a;
        for (int i = 0; i < 2; i++) a[i] = (t >= i) && (t < i + k);
        if (a != 2'b00) push(acc + 2 + t, 0, a, a, 0, 0, 0, 1, {tag, "_feed"});
      end
      d = acc + 2 + k + 2;
    end else begin
      d = acc + 2;
    end
    for (int c = 0; c <= s; c++) push(d + c, 0, 2'b00, 2'b00, 1, 0, 0, 1, {tag, "_row0"});
    push(d + s + 1, 0, 2'b00, 2'b00, 1, 1, 0, 1, {tag, "_row1"});
    push(d + s + 2, 0, 2'b00, 2'b00, 0, 0, 1, 0, {tag, "_done"});
    return d + s + 2;
  endfunction

  // Hand-written trace for k_len=3 with ready held high.
  function automatic int push_k3(int acc, string tag);
    push(acc + 1, 1, 2'b00, 2'b00, 0, 0, 0, 1, {tag, "_clr"});
    push(acc + 2, 0, 2'b01, 2'b01, 0, 0, 0, 1, {tag, "_feed0"});
    push(acc + 3, 0, 2'b11, 2'b11, 0, 0, 0, 1, {tag, "_feed1"});
    push(acc + 4, 0, 2'b11, 2'b11, 0, 0, 0, 1, {tag, "_feed2"});
    push(acc + 5, 0, 2'b10, 2'b10, 0, 0, 0, 1, {tag, "_feed3"});
    push(acc + 7, 0, 2'b00, 2'b00, 1, 0, 0, 1, {tag, "_row0"});
    push(acc + 8, 0, 2'b00, 2'b00, 1, 1, 0, 1, {tag, "_row1"});
    push(acc + 9, 0, 2'b00, 2'b00, 0, 0, 1, 0, {tag, "_done"});
    return acc + 9;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_tile(int k, int s, bit glitch, bit hold, bit hand, string tag);
    int acc, dn, d, p;
    start = 1'b1;
    k_len = 4'(k);
    acc = cyc + 1;
    dn = hand ? push_k3(acc, tag) : push_tile(acc, k, s, tag);
    d = dn - s - 2;
    @(negedge clk);
    while (cyc < dn) begin
      start     = (glitch && cyc >= acc && cyc <= acc + 3) || (hold && cyc >= d);
      k_len     = (glitch && cyc >= acc) ? 4'd7 : 4'(k);
      out_ready = !(cyc >= d && cyc < d + s);
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
`ifdef SEQ_PERF_CNT_EN
    p = dn - acc - 1;
`else
    p = 0;
`endif
    chk({tag, "_perf"}, 64'(perf_cycles), 64'(p));
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, acc_clr, a_en, b_en, out_valid, out_row, done, perf_cycles},
        '0);
    rst = 1'b0;
    @(negedge clk);

    run_tile(3, 0, 0, 0, 1, "t1");
    @(negedge clk);
    run_tile(3, 3, 0, 0, 0, "t2_stall");
    @(negedge clk);
    run_tile(3, 0, 1, 0, 1, "t3_ignore");
    @(negedge clk);
    run_tile(0, 0, 0, 0, 0, "t4_k0");
    @(negedge clk);

    // Abort mid-compute with reset sampled at the fourth edge after accept.
    start = 1'b1; k_len = 4'd3; acc = cyc + 1;
    push(acc + 1, 1, 2'b00, 2'b00, 0, 0, 0, 1, "t5_clr");
    push(acc + 2, 0, 2'b01, 2'b01, 0, 0, 0, 1, "t5_feed0");
    push(acc + 3, 0, 2'b11, 2'b11, 0, 0, 0, 1, "t5_feed1");
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_abort_outputs", {busy, acc_clr, a_en, b_en, out_valid, out_row, done, perf_cycles},
        '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_tile(1, 0, 0, 0, 0, "t5_k1");
    @(negedge clk);

    run_tile(15, 0, 0, 1, 0, "t6_k15");
    run_tile(2, 1, 0, 0, 0, "t6_b2b");

    repeat (5) @(negedge clk);
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
